// File: rtl/comp_fir_pkg.sv
// rtl/comp_fir_pkg.sv - constants, folded coefficient table and FSM states for comp_fir_dec2
package comp_fir_pkg;

  localparam int NTAPS = 15;
  localparam int CW    = 16;
  localparam int SHIFT = 14;
  localparam int NHALF = (NTAPS + 1) / 2;

  // Q2.14 droop compensation, h[14-i] == h[i]; DC gain 16556/16384
  localparam logic signed [CW-1:0] H [NHALF] = '{
    -16'sd48, 16'sd112, -16'sd236, 16'sd430,
    -16'sd740, 16'sd1310, -16'sd2790, 16'sd20480
  };

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    ROUND
  } state_t;

endpackage

// File: rtl/sat_round.sv
// rtl/sat_round.sv - round-half-up, arithmetic right shift and saturate to OW bits
module sat_round #(
  parameter int AW    = 54,
  parameter int SHIFT = 14,
  parameter int OW    = 24
) (
  input  logic signed [AW-1:0] acc,
  output logic signed [OW-1:0] out,
  output logic                 sat
);

  localparam logic signed [AW:0] HALF  = {{(AW+1-SHIFT){1'b0}}, 1'b1, {(SHIFT-1){1'b0}}};
  localparam logic signed [AW:0] MAX_V = {{(AW-OW+2){1'b0}}, {(OW-1){1'b1}}};
  localparam logic signed [AW:0] MIN_V = {{(AW-OW+2){1'b1}}, {(OW-1){1'b0}}};

  logic signed [AW:0] sum;
  logic signed [AW:0] shr;

  // one extra bit keeps the rounding add from wrapping at the positive extreme
  always_comb begin
    sum = $signed({acc[AW-1], acc}) + HALF;
    shr = sum >>> SHIFT;
    sat = 1'b0;
    out = shr[OW-1:0];
    if (shr > MAX_V) begin
      out = MAX_V[OW-1:0];
      sat = 1'b1;
    end else if (shr < MIN_V) begin
      out = MIN_V[OW-1:0];
      sat = 1'b1;
    end
  end

endmodule

// File: rtl/comp_fir_dec2.sv
// rtl/comp_fir_dec2.sv - symmetric 15-tap droop-compensation FIR, decimate by 2, one serial MAC
module comp_fir_dec2
  import comp_fir_pkg::*;
#(
  parameter int DW = 33,
  parameter int OW = 24,
  parameter int AW = 54
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic signed [DW-1:0] in,
  input  logic                 valid_in,
  output logic signed [OW-1:0] out,
  output logic                 valid_out,
  output logic                 sat,
  output logic                 overrun
);

  state_t state, state_nx;
  logic [3:0] idx;
  logic phase;
  logic pend_full;
  logic signed [DW-1:0] pend;
  logic signed [DW-1:0] x [NTAPS];
  logic signed [AW-1:0] acc;

  logic idle, accept, trigger;
  logic signed [DW-1:0] acc_sample;
  logic signed [DW-1:0] x_lo, x_hi;
  logic signed [DW:0] pre;
  logic signed [CW-1:0] coef;
  logic signed [DW+CW:0] prod;
  logic signed [OW-1:0] rnd_out;
  logic rnd_sat;

  // a queued sample has priority over a fresh one when the MAC frees up
  always_comb begin
    idle       = (state == IDLE);
    accept     = idle && (valid_in || pend_full);
    acc_sample = pend_full ? pend : in;
    trigger    = accept && phase;
  end

  always_comb begin
    x_lo = x[idx];
    x_hi = x[4'd14 - idx];
    coef = H[idx[2:0]];
    if (idx == 4'd7) pre = {x_lo[DW-1], x_lo};
    else             pre = {x_lo[DW-1], x_lo} + {x_hi[DW-1], x_hi};
    prod = $signed({{CW{pre[DW]}}, pre}) * $signed({{(DW+1){coef[CW-1]}}, coef});
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (trigger) state_nx = MAC;
      MAC:     if (idx == 4'd7) state_nx = ROUND;
      ROUND:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase     <= 1'b0;
      pend_full <= 1'b0;
      pend      <= '0;
      idx       <= '0;
      acc       <= '0;
      out       <= '0;
      valid_out <= 1'b0;
      sat       <= 1'b0;
      overrun   <= 1'b0;
      for (int k = 0; k < NTAPS; k++) x[k] <= '0;
    end else begin
      valid_out <= 1'b0;
      if (accept) begin
        x[0] <= acc_sample;
        for (int k = 1; k < NTAPS; k++) x[k] <= x[k-1];
        phase <= ~phase;
      end
      if (idle) begin
        if (pend_full && valid_in)  pend <= in;
        if (pend_full && !valid_in) pend_full <= 1'b0;
      end else if (valid_in) begin
        if (pend_full) begin
          overrun <= 1'b1;
        end else begin
          pend      <= in;
          pend_full <= 1'b1;
        end
      end
      case (state)
        IDLE: begin
          idx <= '0;
          acc <= '0;
        end
        MAC: begin
          acc <= acc + $signed({{(AW-DW-CW-1){prod[DW+CW]}}, prod});
          idx <= idx + 4'd1;
        end
        ROUND: begin
          out       <= rnd_out;
          sat       <= rnd_sat;
          valid_out <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  sat_round #(
    .AW   (AW),
    .SHIFT(SHIFT),
    .OW   (OW)
  ) u_sat_round (
    .acc(acc),
    .out(rnd_out),
    .sat(rnd_sat)
  );

endmodule
